// File: rtl/clb_cfg_loader.sv
// Serial configuration loader for one CLB: preamble hunt, 37-bit frame shift, even-parity check, atomic commit.
// Optional readback of the committed configuration is compiled in with `define CFG_READBACK_EN.
module clb_cfg_loader #(
  parameter int          CFG_W    = 37,
  parameter logic [7:0]  PREAMBLE = 8'b0010_1101,
  // Packed from the per-field reset values: MEM=16'h0116, mux2/3/4=2'b10, mux5/6=2'b00, O2M=6'b000111
  parameter logic [CFG_W-1:0] CFG_RST = 37'h00_22C5_4038
) (
  input  logic        K,
  input  logic        RST,
  input  logic        DIN,
  input  logic        DIN_VALID,
`ifdef CFG_READBACK_EN
  input  logic        RB_REQ,
  output logic        DOUT,
  output logic        DOUT_VALID,
`endif
  output logic [15:0] MEM,
  output logic [1:0]  COMBOPTION,
  output logic [1:0]  MUX2SEL,
  output logic [1:0]  MUX3SEL,
  output logic [1:0]  MUX4SEL,
  output logic [1:0]  MUX5SEL,
  output logic [1:0]  MUX6SEL,
  output logic [5:0]  O2M,
  output logic [1:0]  DQMUX,
  output logic        FLOPORLATCH,
  output logic        BUSY,
  output logic        CFG_DONE,
  output logic        CFG_ERR
);

  // state    | meaning
  // IDLE     | hunting for preamble in the valid bit stream
  // SHIFT    | collecting the 37 payload bits into the shadow register
  // PARITY   | next valid bit is the even-parity bit
  // CHECK    | commit shadow (pass) or flag error (fail), one cycle
  // READBACK | streaming committed config plus parity on DOUT (optional)
  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    PARITY,
    CHECK
`ifdef CFG_READBACK_EN
    , READBACK
`endif
  } state_t;

  localparam int CNT_W = $clog2(CFG_W + 1);

  state_t             state_q, state_d;
  logic [6:0]         hist_q;   // only the 7 most recent bits matter; DIN supplies the 8th
  logic [CFG_W-1:0]   shadow_q;
  logic [CFG_W-1:0]   cfg_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic               par_q;
  logic               pass_q;
  logic               done_q;
  logic               err_q;
  logic               commit;
  logic               reject;
`ifdef CFG_READBACK_EN
  logic               rb_start;
  logic [CFG_W-1:0]   rb_sh_q;
  logic [CNT_W-1:0]   rb_cnt_q;
  logic               dout_q;
  logic               dout_valid_q;
`endif

  always_ff @(posedge K) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    reject  = 1'b0;
    BUSY    = 1'b0;
`ifdef CFG_READBACK_EN
    rb_start = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef CFG_READBACK_EN
        if (RB_REQ) begin
          state_d  = READBACK;
          rb_start = 1'b1;
        end else
`endif
        if (DIN_VALID && ({hist_q, DIN} == PREAMBLE)) state_d = SHIFT;
      end
      SHIFT: begin
        BUSY = 1'b1;
        if (DIN_VALID && (bit_cnt_q == '0)) state_d = PARITY;
      end
      PARITY: begin
        BUSY = 1'b1;
        if (DIN_VALID) state_d = CHECK;
      end
      CHECK: begin
        BUSY    = 1'b1;
        state_d = IDLE;
        commit  = pass_q;
        reject  = ~pass_q;
      end
`ifdef CFG_READBACK_EN
      READBACK: begin
        BUSY = 1'b1;
        if (rb_cnt_q == '0) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge K) begin
    if (RST) begin
      hist_q    <= '0;
      shadow_q  <= '0;
      cfg_q     <= CFG_RST;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= commit;
      err_q  <= reject;
      if (commit) cfg_q <= shadow_q;
      case (state_q)
        IDLE: begin
          bit_cnt_q <= CNT_W'(CFG_W - 1);
          par_q     <= 1'b0;
          if (DIN_VALID) hist_q <= {hist_q[5:0], DIN};
        end
        SHIFT: if (DIN_VALID) begin
          shadow_q <= {shadow_q[CFG_W-2:0], DIN};
          par_q    <= par_q ^ DIN;
          if (bit_cnt_q != '0) bit_cnt_q <= bit_cnt_q - CNT_W'(1);
        end
        PARITY: if (DIN_VALID) pass_q <= ~(par_q ^ DIN);
        // back-to-back frames must present a complete fresh preamble
        CHECK: hist_q <= '0;
        default: ;
      endcase
    end
  end

`ifdef CFG_READBACK_EN
  always_ff @(posedge K) begin
    if (RST) begin
      rb_sh_q      <= '0;
      rb_cnt_q     <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else if (rb_start) begin
      // MSB goes out immediately; the shifter holds the rest with parity appended
      rb_sh_q      <= {cfg_q[CFG_W-2:0], ^cfg_q};
      rb_cnt_q     <= CNT_W'(CFG_W);
      dout_q       <= cfg_q[CFG_W-1];
      dout_valid_q <= 1'b1;
    end else if (state_q == READBACK) begin
      if (rb_cnt_q == '0) begin
        dout_q       <= 1'b0;
        dout_valid_q <= 1'b0;
      end else begin
        dout_q   <= rb_sh_q[CFG_W-1];
        rb_sh_q  <= {rb_sh_q[CFG_W-2:0], 1'b0};
        rb_cnt_q <= rb_cnt_q - CNT_W'(1);
      end
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
`endif

  assign MEM         = cfg_q[36:21];
  assign COMBOPTION  = cfg_q[20:19];
  assign MUX2SEL     = cfg_q[18:17];
  assign MUX3SEL     = cfg_q[16:15];
  assign MUX4SEL     = cfg_q[14:13];
  assign MUX5SEL     = cfg_q[12:11];
  assign MUX6SEL     = cfg_q[10:9];
  assign O2M         = cfg_q[8:3];
  assign DQMUX       = cfg_q[2:1];
  assign FLOPORLATCH = cfg_q[0];
  assign CFG_DONE    = done_q;
  assign CFG_ERR     = err_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Scoreboard bench for clb_cfg_loader: random framed stimulus, reference model of committed config.
// Readback checks are compiled only when CFG_READBACK_EN is defined.
module tb_clb_cfg_loader;

  localparam logic [7:0]  PRE     = 8'b0010_1101;
  localparam logic [36:0] RST_CFG = {16'h0116, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00,
                                     6'b000111, 2'b00, 1'b0};

  logic        K = 1'b0;
  logic        RST = 1'b1;
  logic        DIN = 1'b0;
  logic        DIN_VALID = 1'b0;
  logic [15:0] MEM;
  logic [1:0]  COMBOPTION, MUX2SEL, MUX3SEL, MUX4SEL, MUX5SEL, MUX6SEL, DQMUX;
  logic [5:0]  O2M;
  logic        FLOPORLATCH, BUSY, CFG_DONE, CFG_ERR;
`ifdef CFG_READBACK_EN
  logic        RB_REQ = 1'b0;
  logic        DOUT, DOUT_VALID;
`endif

  clb_cfg_loader dut (
    .K(K), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID),
`ifdef CFG_READBACK_EN
    .RB_REQ(RB_REQ), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
`endif
    .MEM(MEM), .COMBOPTION(COMBOPTION), .MUX2SEL(MUX2SEL), .MUX3SEL(MUX3SEL),
    .MUX4SEL(MUX4SEL), .MUX5SEL(MUX5SEL), .MUX6SEL(MUX6SEL), .O2M(O2M),
    .DQMUX(DQMUX), .FLOPORLATCH(FLOPORLATCH), .BUSY(BUSY),
    .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR)
  );

  always #5 K = ~K;

  int cyc = 0;
  always @(posedge K) cyc <= cyc + 1;

  typedef struct {
    logic        pass;
    logic [36:0] cfg;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [36:0] model_cfg = RST_CFG;
  logic        expect_busy = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [36:0] dut_cfg();
    return {MEM, COMBOPTION, MUX2SEL, MUX3SEL, MUX4SEL, MUX5SEL, MUX6SEL, O2M, DQMUX, FLOPORLATCH};
  endfunction

  // Monitor: every pulse must match the head of the scoreboard; config may only move on a commit.
  logic [36:0] prev_cfg = RST_CFG;
  always @(negedge K) begin
    logic [36:0] cur;
    exp_t e;
    cur = dut_cfg();
    if (!RST) begin
      if (expect_busy) check("busy_in_frame", 64'(BUSY), 64'(1));
      if (CFG_DONE || CFG_ERR) begin
        check("done_err_exclusive", 64'(CFG_DONE & CFG_ERR), 64'(0));
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none", CFG_DONE, CFG_ERR);
        end else begin
          e = sb.pop_front();
          check("pulse_is_done", 64'(CFG_DONE), 64'(e.pass));
          check("pulse_cycle", 64'(cyc), 64'(e.cyc));
          check("cfg_after_check", 64'(cur), 64'(e.cfg));
        end
      end else if (cur !== prev_cfg) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cfg_changed_without_commit: got %0h expected %0h", cur, prev_cfg);
      end
    end
    prev_cfg = cur;
  end

  task automatic drive_bit(input logic b, input int stall_pct);
    while (int'($urandom_range(99)) < stall_pct) begin
      DIN_VALID = 1'b0;
      DIN = 1'($urandom_range(1));
      @(posedge K); #1;
    end
    DIN_VALID = 1'b1;
    DIN = b;
    @(posedge K); #1;
    DIN_VALID = 1'b0;
  endtask

  function automatic logic even_par(input logic [36:0] v);
    return 1'($countones(v) % 2);
  endfunction

  // Sends optional random lead-in (never containing an early preamble), the preamble, n_bits of payload
  // and, for a full frame, the parity bit; the expected outcome is pushed to the scoreboard.
  task automatic send_frame(input logic [36:0] cfg, input logic pbit, input int stall_pct, input int n_bits);
    logic bits[$];
    logic premature;
    logic [7:0] w;
    exp_t e;
    do begin
      bits = {};
      repeat (7) bits.push_back(1'b0);
      repeat ($urandom_range(6)) bits.push_back(1'($urandom_range(1)));
      for (int i = 7; i >= 0; i--) bits.push_back(PRE[i]);
      premature = 1'b0;
      for (int i = 7; i < bits.size() - 1; i++) begin
        for (int j = 0; j < 8; j++) w[7-j] = bits[i-7+j];
        if (w == PRE) premature = 1'b1;
      end
    end while (premature);
    for (int i = 7; i < bits.size(); i++) drive_bit(bits[i], stall_pct);
    expect_busy = 1'b1;
    for (int i = 36; i > 36 - n_bits; i--) drive_bit(cfg[i], stall_pct);
    if (n_bits < 37) begin
      expect_busy = 1'b0;
      return;
    end
    drive_bit(pbit, stall_pct);
    expect_busy = 1'b0;
    e.pass = (even_par(cfg) ^ pbit) == 1'b0;
    if (e.pass) model_cfg = cfg;
    e.cfg = model_cfg;
    e.cyc = cyc + 1;
    sb.push_back(e);
    repeat (3) @(posedge K);
    #1;
    check("idle_after_frame", 64'(BUSY), 64'(0));
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    DIN_VALID = 1'b0;
    DIN = 1'b0;
    expect_busy = 1'b0;
    repeat (n) @(posedge K);
    #1;
    RST = 1'b0;
    model_cfg = RST_CFG;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [36:0] cfg;
    logic [63:0] r;
    logic        pbit;
    do_reset(2);
    check("rst_cfg", 64'(dut_cfg()), 64'(RST_CFG));
    check("rst_mem", 64'(MEM), 64'h0116);
    check("rst_mux2", 64'(MUX2SEL), 64'(2'b10));
    check("rst_o2m", 64'(O2M), 64'(6'b000111));
    check("rst_busy", 64'(BUSY), 64'(0));
    check("rst_pulses", 64'({CFG_DONE, CFG_ERR}), 64'(0));

    cfg = 37'h1F_FFF0_0001;
    send_frame(cfg, ~even_par(cfg), 0, 37);
    check("bad_keeps_mem", 64'(MEM), 64'h0116);

    send_frame(cfg, even_par(cfg), 0, 37);
    check("good_mem", 64'(MEM), 64'hFFFF);
    check("good_comb", 64'(COMBOPTION), 64'(2'b10));
    check("good_flop", 64'(FLOPORLATCH), 64'(1));

    r = {$urandom(), $urandom()};
    send_frame(r[36:0], even_par(r[36:0]), 50, 37);

    r = {$urandom(), $urandom()};
    send_frame(r[36:0], even_par(r[36:0]), 0, 20);
    do_reset(2);
    check("midframe_rst_cfg", 64'(dut_cfg()), 64'(RST_CFG));
    check("midframe_rst_busy", 64'(BUSY), 64'(0));
    send_frame(r[36:0], even_par(r[36:0]), 0, 37);

`ifdef CFG_READBACK_EN
    begin
      logic rb[$];
      logic [37:0] exp_rb;
      cfg = 37'h15_5555_5555;
      send_frame(cfg, even_par(cfg), 0, 37);
      RB_REQ = 1'b1;
      @(posedge K); #1;
      RB_REQ = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge K);
        if (DOUT_VALID) rb.push_back(DOUT);
      end
      exp_rb = {cfg, even_par(cfg)};
      check("rb_length", 64'(rb.size()), 64'(38));
      for (int i = 0; i < 38 && i < rb.size(); i++)
        check("rb_bit", 64'(rb[i]), 64'(exp_rb[37-i]));
      #1;
    end
`endif

    for (int k = 0; k < 10; k++) begin
      r = {$urandom(), $urandom()};
      pbit = even_par(r[36:0]) ^ ($urandom_range(3) == 0);
      send_frame(r[36:0], pbit, ($urandom_range(1) == 1) ? 30 : 0, 37);
    end

    repeat (5) @(posedge K);
    #1;
    check("final_cfg", 64'(dut_cfg()), 64'(model_cfg));
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
